// File: rtl/apb_master_tmr.sv
// apb_master_tmr
//   APB master that turns single-beat commands into SETUP/ACCESS transfers
//   toward a timer peripheral. A wait-state timeout aborts stuck accesses.
//
// Parameters
//   DATA_WIDTH  APB data width
//   ADDR_WIDTH  APB address width
//   TIMEOUT     maximum number of ACCESS cycles without pready (>= 1)
//
// Ports
//   pclk, preset                     clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready              command handshake, ready only in IDLE
//   cmd_write, cmd_addr, cmd_wdata   command contents
//   rsp_valid                        one-cycle completion pulse
//   rsp_rdata, rsp_err, rsp_timeout  completion result, held until next completion
//   psel, penable, pwrite, paddr, pwdata   APB request
//   prdata, pready, pslverr          APB response
module apb_master_tmr #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic                  psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [ADDR_WIDTH-1:0] paddr,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  pready,
    input  logic                  pslverr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] wait_cnt_q;
    logic [CNT_W-1:0] wait_cnt_inc;

    assign wait_cnt_inc = wait_cnt_q + CNT_W'(1);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= StIdle;
            wait_cnt_q  <= '0;
            cmd_ready   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // cmd_ready rises on the first edge after reset release.
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        state_q    <= StSetup;
                        cmd_ready  <= 1'b0;
                        psel       <= 1'b1;
                        penable    <= 1'b0;
                        pwrite     <= cmd_write;
                        paddr      <= cmd_addr;
                        pwdata     <= cmd_wdata;
                        wait_cnt_q <= '0;
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
                    penable <= 1'b1;
                end
                StAccess: begin
                    // pready wins over a timeout landing on the same edge.
                    if (pready) begin
                        state_q     <= StIdle;
                        cmd_ready   <= 1'b1;
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= pwrite ? '0 : prdata;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                    end else begin
                        wait_cnt_q <= wait_cnt_inc;
                        if (wait_cnt_inc == CNT_LIMIT) begin
                            state_q     <= StIdle;
                            cmd_ready   <= 1'b1;
                            psel        <= 1'b0;
                            penable     <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_rdata   <= '0;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cmd_ready <= 1'b0;
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_tmr.sv
// Scoreboard bench for apb_master_tmr: stimulus pushes expected bus shape and
// response; negedge monitors pop and compare. A small slave model answers
// ACCESS cycles using the bus expectation at the queue head.
module tb_apb_master_tmr;

    logic       pclk = 1'b0;
    logic       preset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_write = 1'b0;
    logic [2:0] cmd_addr = '0;
    logic [7:0] cmd_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       rsp_timeout;
    logic       psel, penable, pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata = '0;
    logic       pready = 1'b0;
    logic       pslverr = 1'b0;

    apb_master_tmr #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .TIMEOUT(16)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit         write;
        logic [2:0] addr;
        logic [7:0] wdata;
        int         wait_n;   // ACCESS cycles with pready=0 before pready=1
        bit         slverr;
        logic [7:0] prdata;
        int         acc_len;  // expected ACCESS cycles
    } bus_t;

    typedef struct {
        logic [7:0] rdata;
        bit         err;
        bit         tmo;
        int         lat;      // cycles from accept cycle to rsp_valid cycle
    } rsp_t;

    bus_t bq[$];
    rsp_t rq[$];
    int   aq[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ovl    = 0;

    always @(posedge pclk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bus monitor and slave model.
    int         setup_cnt = 0;
    int         acc_cnt   = 0;
    bit         in_xfer   = 0;
    bit         unstable  = 0;
    bit         cap_wr;
    logic [2:0] cap_addr;
    logic [7:0] cap_wdata;

    always @(negedge pclk) begin
        if (preset) begin
            setup_cnt = 0; acc_cnt = 0; in_xfer = 0; unstable = 0;
            pready = 1'b0; pslverr = 1'b0;
        end else if (psel && !penable) begin
            if (!in_xfer) begin
                cap_wr = pwrite; cap_addr = paddr; cap_wdata = pwdata;
            end
            in_xfer = 1; setup_cnt++;
            // Garbage outside ACCESS must be ignored.
            pready = 1'b1; pslverr = 1'b1; prdata = 8'hFF;
        end else if (psel && penable) begin
            if (!in_xfer) begin
                cap_wr = pwrite; cap_addr = paddr; cap_wdata = pwdata;
            end
            in_xfer = 1; acc_cnt++;
            if (pwrite !== cap_wr || paddr !== cap_addr || pwdata !== cap_wdata) unstable = 1;
            if (bq.size() > 0) begin
                pready  = ((acc_cnt - 1) == bq[0].wait_n);
                pslverr = bq[0].slverr;
                prdata  = bq[0].prdata;
            end else begin
                pready = 1'b0; pslverr = 1'b0; prdata = 8'h00;
            end
        end else begin
            if (in_xfer) begin
                if (bq.size() == 0) begin
                    check("unexpected_transfer", 1, 0);
                end else begin
                    bus_t e;
                    e = bq.pop_front();
                    check("setup_len", setup_cnt, 1);
                    check("access_len", acc_cnt, e.acc_len);
                    check("pwrite", {31'b0, cap_wr}, {31'b0, e.write});
                    check("paddr", {29'b0, cap_addr}, {29'b0, e.addr});
                    check("pwdata", {24'b0, cap_wdata}, {24'b0, e.wdata});
                    check("apb_stable", {31'b0, unstable}, 0);
                end
            end
            setup_cnt = 0; acc_cnt = 0; in_xfer = 0; unstable = 0;
            pready = 1'b1; pslverr = 1'b1; prdata = 8'hFF;
        end
    end

    // Response monitor.
    always @(negedge pclk) begin
        if (preset) begin
            aq.delete();
        end else begin
            if (rsp_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected_rsp_valid", 1, 0);
                end else begin
                    rsp_t r;
                    r = rq.pop_front();
                    check("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, r.rdata});
                    check("rsp_err", {31'b0, rsp_err}, {31'b0, r.err});
                    check("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, r.tmo});
                    if (aq.size() > 0) check("rsp_latency", cyc - aq.pop_front(), r.lat);
                    else check("rsp_without_accept", 1, 0);
                end
            end
            if (cmd_valid && cmd_ready) begin
                aq.push_back(cyc);
                if (rsp_valid) ovl++;
            end
        end
    end

    task automatic issue(input bit wr, input logic [2:0] a, input logic [7:0] d,
                         input int wait_n, input bit se, input logic [7:0] prd,
                         input int exp_acc, input logic [7:0] exp_rdata,
                         input bit exp_err, input bit exp_tmo,
                         input bit hold, input bit track);
        bit accepted;
        if (track) begin
            bq.push_back('{write: wr, addr: a, wdata: d, wait_n: wait_n, slverr: se,
                           prdata: prd, acc_len: exp_acc});
            rq.push_back('{rdata: exp_rdata, err: exp_err, tmo: exp_tmo, lat: 2 + exp_acc});
        end
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
        accepted = 0;
        for (int i = 0; i < 40 && !accepted; i++) begin
            @(negedge pclk);
            if (cmd_ready) accepted = 1;
        end
        if (!accepted) check("cmd_accept_timeout", 0, 1);
        @(posedge pclk); #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit done;
        done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge pclk);
            if (rq.size() == 0 && bq.size() == 0) done = 1;
        end
        if (!done) check("drain_timeout", 0, 1);
        @(posedge pclk); #1;
    endtask

    initial begin
        #12;
        check("rst_cmd_ready", {31'b0, cmd_ready}, 0);
        check("rst_psel", {31'b0, psel}, 0);
        check("rst_penable", {31'b0, penable}, 0);
        check("rst_pwrite", {31'b0, pwrite}, 0);
        check("rst_paddr", {29'b0, paddr}, 0);
        check("rst_pwdata", {24'b0, pwdata}, 0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 0);
        check("rst_rsp_rdata", {24'b0, rsp_rdata}, 0);
        check("rst_rsp_err", {30'b0, rsp_err, rsp_timeout}, 0);
        @(posedge pclk); #1;
        preset = 1'b0;
        check("rel_cmd_ready_low", {31'b0, cmd_ready}, 0);
        @(posedge pclk); #1;
        check("rel_cmd_ready_high", {31'b0, cmd_ready}, 1);

        // Write, immediate pready; prdata nonzero but write returns 0.
        issue(1, 3'b010, 8'h5A, 0, 0, 8'hA5, 1, 8'h00, 0, 0, 0, 1);
        drain();
        // Read with three wait states.
        issue(0, 3'b011, 8'h00, 3, 0, 8'h82, 4, 8'h82, 0, 0, 0, 1);
        drain();
        // Slave error on write.
        issue(1, 3'b111, 8'h33, 0, 1, 8'h44, 1, 8'h00, 1, 0, 0, 1);
        drain();
        // Timeout: pready never rises.
        issue(0, 3'b001, 8'h00, 1000, 0, 8'hEE, 16, 8'h00, 1, 1, 0, 1);
        drain();
        // pready on the 16th ACCESS cycle completes normally.
        issue(0, 3'b100, 8'h00, 15, 0, 8'h3C, 16, 8'h3C, 0, 0, 0, 1);
        drain();
        // Back-to-back writes with cmd_valid held.
        issue(1, 3'b010, 8'h11, 0, 0, 8'h00, 1, 8'h00, 0, 0, 1, 1);
        issue(1, 3'b011, 8'h82, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0, 1);
        drain();
        check("b2b_accept_in_rsp_cycle", ovl, 1);
        // Reset during the 2nd ACCESS cycle; slave withholds pready.
        issue(0, 3'b101, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
        @(posedge pclk); #1;
        @(posedge pclk); #2;
        check("pre_rst_access", {30'b0, psel, penable}, 2'b11);
        preset = 1'b1;
        #1;
        check("midrst_psel", {31'b0, psel}, 0);
        check("midrst_penable", {31'b0, penable}, 0);
        check("midrst_cmd_ready", {31'b0, cmd_ready}, 0);
        repeat (2) @(posedge pclk);
        #1 preset = 1'b0;
        check("midrst_rel_cmd_ready_low", {31'b0, cmd_ready}, 0);
        @(posedge pclk); #1;
        check("midrst_rel_cmd_ready_high", {31'b0, cmd_ready}, 1);
        check("midrst_idle_psel", {31'b0, psel}, 0);
        repeat (5) @(posedge pclk);
        #1;
        check("final_queues_empty", rq.size() + bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master_tmr.md
APB_MASTER_TMR -- requirements
Module: apb_master_tmr

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 8, APB data width.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 3, APB address width.
REQ-003 SHALL provide parameter TIMEOUT, default 16, which is the maximum number of ACCESS cycles without pready.
REQ-004 SHALL have port pclk, input, 1, the single clock, with all logic on its rising edge.
REQ-005 SHALL have port preset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port cmd_valid, input, 1, meaning a command is offered.
REQ-007 SHALL have port cmd_ready, output, 1, meaning the block can accept a command.
REQ-008 SHALL have port cmd_write, input, 1, where 1 is a write and 0 is a read.
REQ-009 SHALL have port cmd_addr, input, ADDR_WIDTH, the target register address.
REQ-010 SHALL have port cmd_wdata, input, DATA_WIDTH, the write data.
REQ-011 SHALL have port rsp_valid, output, 1, a one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata, output, DATA_WIDTH, the read data captured at completion.
REQ-013 SHALL have port rsp_err, output, 1, set on slave error or timeout.
REQ-014 SHALL have port rsp_timeout, output, 1, set when the error was caused by timeout.
REQ-015 SHALL have APB master ports to the timer: psel, penable and pwrite as 1-bit outputs, paddr as an ADDR_WIDTH output, and pwdata as a DATA_WIDTH output.
REQ-016 SHALL have APB slave-response inputs: prdata (DATA_WIDTH), pready (1) and pslverr (1).

Function
REQ-017 SHALL implement FSM states IDLE, SETUP and ACCESS, with all outputs registered.
REQ-018 SHALL drive cmd_ready=1 only in IDLE; a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-019 SHALL transition IDLE→SETUP on acceptance and latch cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata.
REQ-020 SHALL drive psel=1, penable=0 in SETUP for exactly one cycle, then transition SETUP→ACCESS.
REQ-021 SHALL drive psel=1, penable=1 in ACCESS and hold paddr, pwrite and pwdata stable from SETUP until exit.
REQ-022 SHALL complete a transfer at the first ACCESS rising edge with pready=1, then go ACCESS→IDLE.
- On completion, rsp_rdata=prdata for reads and 0 for writes.
- rsp_err=pslverr.
- rsp_timeout=0.
REQ-023 SHALL count ACCESS cycles with pready=0 in a counter of width $clog2(TIMEOUT+1), cleared on entry to SETUP.
REQ-024 SHALL abort when the counter reaches TIMEOUT and pready=0.
- rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Go ACCESS→IDLE.
REQ-025 SHALL give pready=1 priority over timeout on the same cycle, so the transfer completes normally.
REQ-026 SHALL pulse rsp_valid for exactly one cycle, the cycle after the completion or abort edge (the first IDLE cycle).
REQ-027 SHALL hold rsp_rdata, rsp_err and rsp_timeout until the next completion.
REQ-028 SHALL drive psel=0 and penable=0 in IDLE; paddr and pwdata retain their last values.
REQ-029 SHALL accept a new command during the IDLE cycle in which rsp_valid is high, so the minimum period is 3 cycles per unit-latency transfer.
REQ-030 SHALL ignore cmd_* inputs outside IDLE.
REQ-031 SHALL ignore pready, pslverr and prdata outside ACCESS.

Reset
REQ-032 SHALL, on preset=1, immediately and asynchronously set:
- FSM to IDLE;
- psel, penable, pwrite = 0;
- paddr, pwdata = 0;
- cmd_ready = 0 while preset=1, and 1 from the first edge after release;
- rsp_valid, rsp_err, rsp_timeout = 0;
- rsp_rdata = 0;
- the timeout counter to 0.
REQ-033 SHALL, when reset is asserted mid-SETUP or mid-ACCESS, abandon the transfer with no rsp_valid pulse.

Verification
REQ-034 SHALL cover a write with immediate pready.
- Stimulus: cmd write, addr=3'b010, wdata=8'h5A; pready=1.
- Response: SETUP and ACCESS one cycle each with paddr=2, pwdata=0x5A; rsp_valid pulses 3 cycles after acceptance with rsp_err=0.
REQ-035 SHALL cover a read with wait states.
- Stimulus: read addr=3'b011; pready low for 3 ACCESS cycles; prdata=8'h82.
- Response: ACCESS lasts 4 cycles; rsp_rdata=0x82 and rsp_err=0.
REQ-036 SHALL cover a slave error.
- Stimulus: write addr=3'b111; pready=1 with pslverr=1.
- Response: rsp_err=1 and rsp_timeout=0.
REQ-037 SHALL cover timeout.
- Stimulus: TIMEOUT=16; pready held 0.
- Response: abort after 16 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; psel=0 next cycle.
- Sub-case: pready=1 on the 16th cycle completes normally.
REQ-038 SHALL cover back-to-back commands.
- Stimulus: a write to TDR (3'b010) then a write to TCR (3'b011, data 8'h82), with cmd_valid held high.
- Response: the second command is accepted in the rsp_valid cycle of the first, the two transfers are 3 cycles apart, and APB signals stay stable within each transfer.
REQ-039 SHALL cover reset mid-ACCESS.
- Stimulus: assert preset during the 2nd ACCESS cycle.
- Response: psel and penable drop immediately with no rsp_valid pulse; cmd_ready=1 on the first edge after release.
